// File: rtl/iter_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   mult_state_t       : controller states (IDLE, RUN, FIX, DONE)
//   MULT_WIDTH_DEFAULT : default operand width
//   mult_cnt_w()       : width of the step counter for a given operand width
//   MULT_CNT_W         : step-counter width at the default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 64;

  function automatic int mult_cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int MULT_CNT_W = mult_cnt_w(MULT_WIDTH_DEFAULT);

endpackage

// File: rtl/iter_mult_if.sv
// Request/response bundle of the iterative multiplier.
//   master : drives start, flush, signed_op, a, b; observes the result side
//   slave  : the multiplier; drives busy, done, result, result_hi and the
//            condition bits zero/negative/overflow/carryout
interface iter_mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) ();

  logic             start;
  logic             flush;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             carryout;

  modport master (
    output start, flush, signed_op, a, b,
    input  busy, done, result, result_hi, zero, negative, overflow, carryout
  );

  modport slave (
    input  start, flush, signed_op, a, b,
    output busy, done, result, result_hi, zero, negative, overflow, carryout
  );

endinterface

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier for the execute stage.
// Produces a 2*WIDTH-bit product in WIDTH+2 cycles from accept to the edge
// that samples done, and feeds the condition-flag register directly
// (done is its setFlags strobe).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; clears every register and output
//   bus   : iter_mult_if.slave (start/flush/signed_op/a/b in;
//           busy/done/result/result_hi/zero/negative/overflow/carryout out)
module iter_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  iter_mult_if.slave  bus
);

  localparam int CNT_W = mult_cnt_w(WIDTH);

  mult_state_t          state;
  mult_state_t          state_nx;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   prod;
  logic                 neg;
  logic                 sop;
  logic                 last_step;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     result_hi;
  logic                 zero;
  logic                 negative;
  logic                 overflow;

  // |x| when en is set. The magnitude of the most negative value wraps to the
  // same bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic en);
    return (en && x < 0) ? -x : x;
  endfunction

  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign prod      = neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = RUN;
        RUN:     if (last_step) state_nx = FIX;
        FIX:     state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // done is a decode of the state register, so a flush arriving in DONE
  // cannot retract the strobe already on the wire.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      sop       <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else if (!bus.flush) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sop    <= bus.signed_op;
            mcand  <= {{WIDTH{1'b0}}, magnitude($signed(bus.a), bus.signed_op)};
            mplier <= magnitude($signed(bus.b), bus.signed_op);
            neg    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          // mcand is shifted once per step, so it always equals the latched
          // multiplicand shifted left by count.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        FIX: begin
          result    <= prod[WIDTH-1:0];
          result_hi <= prod[2*WIDTH-1:WIDTH];
          zero      <= (prod[WIDTH-1:0] == '0);
          negative  <= prod[WIDTH-1];
          overflow  <= sop ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                           : (prod[2*WIDTH-1:WIDTH] != '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.result_hi = result_hi;
  assign bus.zero      = zero;
  assign bus.negative  = negative;
  assign bus.overflow  = overflow;
  assign bus.carryout  = 1'b0;

endmodule

// File: tb/tb_iter_mult.sv
module tb_iter_mult;
  import mult_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iter_mult_if #(.WIDTH(W)) bus ();

  iter_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         n;
    logic         o;
    int           e;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_done   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the true mathematical product, split into halves.
  function automatic exp_t model(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] maxs;
    logic signed [2*W-1:0] mins;
    if (sop) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else     p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    maxs = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    mins = ~maxs;
    r.lo = p[W-1:0];
    r.hi = p[2*W-1:W];
    r.z  = (r.lo == '0);
    r.n  = r.lo[W-1];
    r.o  = sop ? (p > maxs || p < mins) : (r.hi != '0);
    r.e  = 0;
    return r;
  endfunction

  function automatic logic [W-1:0] pick(input int mode);
    logic [W-1:0] c [4];
    c[0] = '0;
    c[1] = {1'b1, {(W-1){1'b0}}};
    c[2] = '1;
    c[3] = {1'b0, {(W-1){1'b1}}};
    case (mode)
      0:       return {$urandom, $urandom};
      1:       return W'($urandom_range(0, 255));
      2:       return c[$urandom_range(0, 3)];
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  exp_t got;
  always @(negedge clk) begin
    if (reset && bus.done) begin
      n_done++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        got = q.pop_front();
        chk("result",    bus.result,    got.lo);
        chk("result_hi", bus.result_hi, got.hi);
        chk("zero",      bus.zero,      got.z);
        chk("negative",  bus.negative,  got.n);
        chk("overflow",  bus.overflow,  got.o);
        chk("carryout",  bus.carryout,  1'b0);
        chk("busy_in_done", bus.busy,   1'b1);
        chk("latency",   cyc - got.e,   W + 1);
        last_exp = got;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_done"},      bus.done,      0);
    chk({tag, "_result"},    bus.result,    0);
    chk({tag, "_result_hi"}, bus.result_hi, 0);
    chk({tag, "_zero"},      bus.zero,      0);
    chk({tag, "_negative"},  bus.negative,  0);
    chk({tag, "_overflow"},  bus.overflow,  0);
    chk({tag, "_carryout"},  bus.carryout,  0);
  endtask

  task automatic wait_idle();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.busy && i < 200);
    if (bus.busy) chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic issue(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_it);
    exp_t x;
    wait_idle();
    bus.signed_op = sop;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    if (expect_it) begin
      x   = model(sop, a, b);
      x.e = cyc;
      q.push_back(x);
    end
  endtask

  task automatic wait_done();
    int n0 = n_done;
    int i  = 0;
    while (n_done == n0 && i < W + 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (n_done == n0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    issue(1'b0, 64'd3, 64'd5, 1'b1);                              wait_done();
    issue(1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);          wait_done();
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1);            wait_done();
    issue(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); wait_done();

    // start during RUN is ignored
    issue(1'b0, 64'd1234567, 64'd89, 1'b1);
    repeat (10) @(negedge clk);
    bus.a = 64'd99;
    bus.b = 64'd99;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();

    // flush mid-RUN: no done, previous outputs held
    issue(1'b1, pick(0), pick(0), 1'b0);
    repeat (20) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("busy_after_flush", bus.busy, 0);
    repeat (W + 5) @(negedge clk);
    chk("hold_result",    bus.result,    last_exp.lo);
    chk("hold_result_hi", bus.result_hi, last_exp.hi);
    chk("hold_overflow",  bus.overflow,  last_exp.o);

    // flush and start together in IDLE: nothing accepted
    @(negedge clk);
    bus.a = 64'd7;
    bus.b = 64'd7;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("busy_flush_start", bus.busy, 0);
    repeat (W + 5) @(negedge clk);

    // asynchronous reset mid-operation
    issue(1'b0, '1, '1, 1'b0);
    repeat (30) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 64'd7, 64'd6, 1'b1);
    wait_done();

    for (int k = 0; k < 12; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit           rs;
      rs = 1'($urandom_range(0, 1));
      ra = pick($urandom_range(0, 3));
      rb = pick($urandom_range(0, 3));
      issue(rs, ra, rb, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
